// File: rtl/uart_xfer_ctrl_mc.sv
// Multi-channel UART transfer controller: routes one APB-initiated transfer at a
// time to a UART channel's TX/RX enable, with ctrl gating, WAIT timeout and sticky errors.
module uart_xfer_ctrl_mc #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                transfer,
  input  logic                PWRITE,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic [2*NUM_CH-1:0] ctrl,
  input  logic                PREADY,
  input  logic                uart_run_flag,
  input  logic                err_clr,
  output logic [NUM_CH-1:0]   TXen,
  output logic [NUM_CH-1:0]   RXen,
  output logic                busy,
  output logic                done,
  output logic                error_ctrl,
  output logic                error_timeout,
  output logic [CH_W-1:0]     err_ch
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ERROR} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            dir_q, dir_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            err_ctrl_q, err_ctrl_d;
  logic            err_to_q, err_to_d;
  logic [CH_W-1:0] err_ch_q, err_ch_d;

  logic chValid, txOk, rxOk;
  logic setCtrl, setTo;

  // Channel lookup by comparison keeps every ctrl index in range for any ch_sel.
  always_comb begin
    chValid = 1'b0;
    txOk    = 1'b0;
    rxOk    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) begin
        chValid = 1'b1;
        txOk    = ctrl[2*i];
        rxOk    = ctrl[2*i+1];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    setCtrl  = 1'b0;
    setTo    = 1'b0;
    err_ch_d = err_ch_q;
    if (!uart_run_flag) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            ch_d  = ch_sel;
            dir_d = PWRITE;
            cnt_d = '0;
            if (!chValid || (PWRITE ? !txOk : !rxOk)) begin
              state_d  = ERROR;
              setCtrl  = 1'b1;
              err_ch_d = ch_sel;
            end else begin
              state_d = SETUP;
            end
          end
        end
        SETUP: begin
          state_d = WAIT;
          cnt_d   = '0;
        end
        WAIT: begin
          if (PREADY) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
            state_d  = ERROR;
            setTo    = 1'b1;
            err_ch_d = ch_q;
            cnt_d    = '0;
          end else if (TIMEOUT > 0) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ERROR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // A set in the same cycle as err_clr takes priority.
    err_ctrl_d = setCtrl | (err_ctrl_q & ~err_clr);
    err_to_d   = setTo   | (err_to_q   & ~err_clr);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_ctrl_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_ctrl_q <= err_ctrl_d;
      err_to_q   <= err_to_d;
      err_ch_q   <= err_ch_d;
    end
  end

  always_comb begin
    TXen = '0;
    RXen = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == SETUP || state_q == WAIT) && ch_q == CH_W'(i)) begin
        TXen[i] = dir_q;
        RXen[i] = ~dir_q;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign error_ctrl    = err_ctrl_q;
  assign error_timeout = err_to_q;
  assign err_ch        = err_ch_q;

endmodule

// File: doc/uart_xfer_ctrl_mc.md
Name: uart_xfer_ctrl_mc

Overview:
- Multi-channel successor to the single-channel UART APB transfer FSM.
- Arbitrates one APB-initiated transfer at a time onto one of NUM_CH UART channels, asserting that channel's TXen (write) or RXen (read) until the completer returns PREADY.
- New behaviour: per-channel ctrl gating, direction-mismatch errors, a WAIT timeout, sticky error flags with clear, a completion pulse and registered glitch-free outputs.
- Sits between the APB slave decode and the per-channel UART TX/RX engines.

Parameters:
- NUM_CH, 4, number of UART channels (1..16).
- CH_W, 2, channel-select width (>= clog2(NUM_CH), min 1).
- TIMEOUT, 16, maximum WAIT cycles before timeout error; 0 disables the timeout. Local TO_W = clog2(TIMEOUT+1).

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- transfer  in  1  transfer request, sampled in IDLE only.
- PWRITE  in  1  1=write/TX, 0=read/RX, sampled with transfer.
- ch_sel  in  CH_W  target channel, sampled with transfer.
- ctrl  in  2*NUM_CH  per-channel enables; ctrl[2i] = TX allowed, ctrl[2i+1] = RX allowed.
- PREADY  in  1  completer ready, sampled in WAIT only.
- uart_run_flag  in  1  global run enable; low = abort/hold in IDLE.
- err_clr  in  1  clears the sticky error flags.
- TXen  out  NUM_CH  one-hot TX enable for the active write channel.
- RXen  out  NUM_CH  one-hot RX enable for the active read channel.
- busy  out  1  high in SETUP/WAIT/ERROR.
- done  out  1  one-cycle pulse on successful completion.
- error_ctrl  out  1  sticky: bad channel or direction not enabled.
- error_timeout  out  1  sticky: WAIT exceeded TIMEOUT.
- err_ch  out  CH_W  channel of the most recent error.

Behaviour:
- Reset (async, PRESETn=0):
  - state=IDLE; TXen=0, RXen=0, busy=0, done=0.
  - error_ctrl=0, error_timeout=0, err_ch=0; WAIT counter=0.
- States: IDLE, SETUP, WAIT, ERROR.
  - Outputs are decoded only from registered state, latched channel (ch_q) and latched direction (dir_q), plus registered flags.
  - No combinational path from any input to any output.
- IDLE, with transfer=1 and uart_run_flag=1 at edge k: latch ch_q=ch_sel and dir_q=PWRITE, then:
  - ch_sel >= NUM_CH -> ERROR.
  - Write with ctrl[2*ch]=0 -> ERROR.
  - Read with ctrl[2*ch+1]=0 -> ERROR.
  - Otherwise -> SETUP.
- SETUP (the cycle after edge k):
  - TXen[ch_q]=1 if dir_q=1, else RXen[ch_q]=1.
  - Unconditionally -> WAIT; PREADY is ignored in SETUP.
- WAIT: enable stays asserted; counter starts at 0.
  - PREADY=1 -> IDLE; done=1 and the enable deasserts in the following cycle.
  - PREADY=0 and counter==TIMEOUT-1 (TIMEOUT>0) -> ERROR. WAIT therefore lasts at most TIMEOUT cycles.
  - Otherwise counter+1.
  - PREADY=1 in the final allowed cycle completes normally (done, no error).
- ERROR lasts one cycle, then -> IDLE; TXen/RXen=0.
  - On entry from IDLE: set error_ctrl, err_ch=ch_sel[CH_W-1:0].
  - On entry from WAIT: set error_timeout, err_ch=ch_q.
- Flags:
  - error_ctrl and error_timeout stay set until err_clr=1 clears both.
  - A set and a clear in the same cycle: set wins.
  - err_ch is not cleared by err_clr.
- uart_run_flag=0 at any edge: next state is IDLE and the counter clears.
  - The enable deasserts the next cycle.
  - No done and no error flag are raised.
  - transfer is ignored while uart_run_flag=0.
- Back-to-back: at least one IDLE cycle separates transfers; transfer=1 in the done cycle starts the next transfer.
- ctrl and PWRITE changes after acceptance do not affect the active transfer (latched values are used).
- Reset mid-transfer forces reset values immediately.

Test Plan (NUM_CH=4, TIMEOUT=8):
1. Write: ctrl=8'h01, ch_sel=0, PWRITE=1, transfer pulse; PREADY=1 on the 3rd WAIT cycle -> TXen=4'b0001 for 4 cycles (1 SETUP + 3 WAIT), then done=1 for 1 cycle, busy low after.
2. Read on channel 2: ctrl=8'h20, PWRITE=0, ch_sel=2; PREADY high on the 1st WAIT cycle -> RXen=4'b0100 for 2 cycles, then done.
3. Direction mismatch: ctrl=8'h02, PWRITE=1, ch_sel=0 -> ERROR for 1 cycle, error_ctrl=1 sticky, err_ch=0, no TXen. Pulsing err_clr then clears error_ctrl.
4. Timeout: valid write on channel 3, PREADY held 0 -> TXen=4'b1000 for 9 cycles, then error_timeout=1, err_ch=3, no done. Repeat with PREADY=1 on the 8th WAIT cycle -> done, no error.
5. Abort: uart_run_flag dropped on the 2nd WAIT cycle -> IDLE next cycle, TXen=0, done=0, flags unchanged. A transfer request while the flag is low is ignored.
6. Async reset mid-WAIT, then back-to-back transfers with transfer=1 in the done cycle -> outputs reset immediately; the second transfer enters SETUP the cycle after done.
